// File: rtl/data_table_search_dispatcher.sv
// Dispatches tasks round-robin to idle search engines, arbitrates the shared data-RAM read port, collects results (in-order, or out-of-order with DTS_OOO_EN).
// Latency: zero-cycle task accept and read grant; eng_rd_data_val_o follows its grant by RAM_LATENCY cycles.
// Backpressure: task_ready_o drops while no engine is idle; a result stays presented until result_ready_i is high.
module data_table_search_dispatcher #(
    parameter int ENGINES_CNT = 4,
    parameter int RAM_LATENCY = 2,
    parameter int A_WIDTH     = 10,
    parameter int TASK_W      = 64,
    parameter int RES_W       = 64,
    localparam int TAG_W      = $clog2(ENGINES_CNT) + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [TASK_W-1:0]              task_i,
    input  logic                           task_valid_i,
    output logic                           task_ready_o,
    output logic [TASK_W-1:0]              eng_task_o,
    output logic [ENGINES_CNT-1:0]         eng_task_valid_o,
    input  logic [ENGINES_CNT-1:0]         eng_task_ready_i,
    input  logic [ENGINES_CNT-1:0]         eng_rd_req_i,
    input  logic [ENGINES_CNT*A_WIDTH-1:0] eng_rd_addr_i,
    output logic [ENGINES_CNT-1:0]         eng_rd_gnt_o,
    output logic [ENGINES_CNT-1:0]         eng_rd_data_val_o,
    output logic [A_WIDTH-1:0]             ram_rd_addr_o,
    output logic                           ram_rd_en_o,
    input  logic [ENGINES_CNT*RES_W-1:0]   eng_result_i,
    input  logic [ENGINES_CNT-1:0]         eng_result_valid_i,
    output logic [ENGINES_CNT-1:0]         eng_result_ready_o,
    output logic [RES_W-1:0]               result_o,
    output logic [TAG_W-1:0]               result_tag_o,
    output logic                           result_valid_o,
    input  logic                           result_ready_i,
    output logic                           busy_o
);
    localparam int IDX_W = $clog2(ENGINES_CNT);

    logic [ENGINES_CNT-1:0] busy;
    logic [ENGINES_CNT-1:0] idle;
    logic [TAG_W-1:0]       tag [ENGINES_CNT];
    logic [TAG_W-1:0]       seq_cnt;
    logic [IDX_W-1:0]       disp_ptr, rd_ptr;
    logic [IDX_W-1:0]       sel_idx, gnt_idx, out_idx;
    logic                   sel_found, gnt_found, out_found;
    logic                   task_acc, rd_go, res_go, res_acc;
    logic                   pipe_vld [RAM_LATENCY];
    logic [IDX_W-1:0]       pipe_idx [RAM_LATENCY];
`ifdef DTS_OOO_EN
    logic [IDX_W-1:0]       res_ptr;
`else
    logic [TAG_W-1:0]       next_tag;
`endif

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= ENGINES_CNT) s = s - ENGINES_CNT;
        return IDX_W'(s);
    endfunction

    assign idle = ~busy & eng_task_ready_i;

    // Dispatch and read-grant searches both start at their own rotating pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = disp_ptr;
        gnt_found = 1'b0;
        gnt_idx   = rd_ptr;
        for (int k = 0; k < ENGINES_CNT; k++) begin
            if (!sel_found && idle[wrap_add(disp_ptr, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(disp_ptr, k);
            end
            if (!gnt_found && eng_rd_req_i[wrap_add(rd_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rd_ptr, k);
            end
        end
    end

    always_comb begin
        out_found = 1'b0;
        out_idx   = '0;
`ifdef DTS_OOO_EN
        for (int k = 0; k < ENGINES_CNT; k++) begin
            if (!out_found && busy[wrap_add(res_ptr, k)] && eng_result_valid_i[wrap_add(res_ptr, k)]) begin
                out_found = 1'b1;
                out_idx   = wrap_add(res_ptr, k);
            end
        end
`else
        for (int k = 0; k < ENGINES_CNT; k++) begin
            if (!out_found && busy[k] && tag[k] == next_tag) begin
                out_found = 1'b1;
                out_idx   = IDX_W'(k);
            end
        end
`endif
    end

    // Every output is forced low while reset is asserted, including the pass-through paths.
    assign task_acc       = rst_n_i && task_valid_i && sel_found;
    assign rd_go          = rst_n_i && gnt_found;
    assign res_go         = rst_n_i && out_found;
    assign task_ready_o   = rst_n_i && sel_found;
    assign eng_task_o     = rst_n_i ? task_i : '0;
    assign ram_rd_en_o    = rd_go;
    assign ram_rd_addr_o  = rd_go ? eng_rd_addr_i[gnt_idx*A_WIDTH +: A_WIDTH] : '0;
    assign result_valid_o = res_go && eng_result_valid_i[out_idx];
    assign result_o       = res_go ? eng_result_i[out_idx*RES_W +: RES_W] : '0;
    assign res_acc        = result_valid_o && result_ready_i;
    assign busy_o         = |busy;
`ifdef DTS_OOO_EN
    assign result_tag_o   = res_go ? tag[out_idx] : '0;
`else
    assign result_tag_o   = rst_n_i ? next_tag : '0;
`endif

    always_comb begin
        eng_task_valid_o   = '0;
        eng_rd_gnt_o       = '0;
        eng_rd_data_val_o  = '0;
        eng_result_ready_o = '0;
        if (task_acc) eng_task_valid_o[sel_idx] = 1'b1;
        if (rd_go) eng_rd_gnt_o[gnt_idx] = 1'b1;
        if (pipe_vld[RAM_LATENCY-1]) eng_rd_data_val_o[pipe_idx[RAM_LATENCY-1]] = 1'b1;
        if (res_go) eng_result_ready_o[out_idx] = result_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy     <= '0;
            seq_cnt  <= '0;
            disp_ptr <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < ENGINES_CNT; i++) tag[i] <= '0;
            for (int s = 0; s < RAM_LATENCY; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_idx[s] <= '0;
            end
`ifdef DTS_OOO_EN
            res_ptr  <= '0;
`else
            next_tag <= '0;
`endif
        end else begin
            // sel is never busy and out always is, so these two never touch the same engine.
            if (task_acc) begin
                busy[sel_idx] <= 1'b1;
                tag[sel_idx]  <= seq_cnt;
                seq_cnt       <= seq_cnt + 1'b1;
                disp_ptr      <= wrap_add(sel_idx, 1);
            end
            if (res_acc) begin
                busy[out_idx] <= 1'b0;
`ifdef DTS_OOO_EN
                res_ptr       <= wrap_add(out_idx, 1);
`else
                next_tag      <= next_tag + 1'b1;
`endif
            end
            if (rd_go) rd_ptr <= wrap_add(gnt_idx, 1);
            pipe_vld[0] <= rd_go;
            pipe_idx[0] <= gnt_idx;
            for (int s = 1; s < RAM_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end
        end
    end
endmodule

// File: tb/tb_data_table_search_dispatcher.sv
// Directed bench for data_table_search_dispatcher with 4 engines, RAM_LATENCY 2 and 3-bit tags.
module tb_data_table_search_dispatcher;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [63:0] task_i;
    logic        task_valid_i;
    logic        task_ready_o;
    logic [63:0] eng_task_o;
    logic [3:0]  eng_task_valid_o;
    logic [3:0]  eng_task_ready_i;
    logic [3:0]  eng_rd_req_i;
    logic [39:0] eng_rd_addr_i;
    logic [3:0]  eng_rd_gnt_o;
    logic [3:0]  eng_rd_data_val_o;
    logic [9:0]  ram_rd_addr_o;
    logic        ram_rd_en_o;
    logic [255:0] eng_result_i;
    logic [3:0]  eng_result_valid_i;
    logic [3:0]  eng_result_ready_o;
    logic [63:0] result_o;
    logic [2:0]  result_tag_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic        busy_o;

    logic [63:0] res_val [4];
    int checks = 0;
    int errors = 0;

    assign eng_rd_addr_i = {10'h103, 10'h102, 10'h101, 10'h100};
    assign eng_result_i  = {res_val[3], res_val[2], res_val[1], res_val[0]};

    always #5 clk_i = ~clk_i;

    data_table_search_dispatcher dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .task_i(task_i), .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
        .eng_task_o(eng_task_o), .eng_task_valid_o(eng_task_valid_o), .eng_task_ready_i(eng_task_ready_i),
        .eng_rd_req_i(eng_rd_req_i), .eng_rd_addr_i(eng_rd_addr_i), .eng_rd_gnt_o(eng_rd_gnt_o),
        .eng_rd_data_val_o(eng_rd_data_val_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_en_o(ram_rd_en_o),
        .eng_result_i(eng_result_i), .eng_result_valid_i(eng_result_valid_i),
        .eng_result_ready_o(eng_result_ready_o), .result_o(result_o), .result_tag_o(result_tag_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .busy_o(busy_o)
    );

    typedef struct {
        logic       tv;
        logic [3:0] etr, req, rv;
        logic       rr;
        logic       trdy;
        logic [3:0] etv, gnt, dval;
        logic       resv;
        logic [2:0] rtag;
        logic       bsy;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic idle_inputs();
        task_valid_i = 1'b0; task_i = '0; eng_task_ready_i = '0; eng_rd_req_i = '0;
        eng_result_valid_i = '0; result_ready_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Streaming engine model.
    logic [63:0] e_pay [4];
    logic [3:0]  e_has;
    int          e_cnt [4];

    initial begin
        for (int i = 0; i < 4; i++) res_val[i] = 64'hA0 + 64'(i);
        do_reset();
        #1;
        check("rst busy_o", busy_o, 0);
        check("rst task_ready_o", task_ready_o, 0);
        check("rst result_valid_o", result_valid_o, 0);
        check("rst result_tag_o", result_tag_o, 0);
        next_cycle();

`ifndef DTS_OOO_EN
        //        tv    etr    req    rv     rr    trdy  etv    gnt    dval   resv  rtag  bsy
        vt[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h8, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[4]  = '{1'b1, 4'hF, 4'hD, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[5]  = '{1'b0, 4'hF, 4'hD, 4'h0, 1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[6]  = '{1'b0, 4'hF, 4'hD, 4'h0, 1'b0, 1'b0, 4'h0, 4'h8, 4'h1, 1'b0, 3'd0, 1'b1};
        vt[7]  = '{1'b0, 4'hF, 4'hD, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h4, 1'b0, 3'd0, 1'b1};
        vt[8]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h8, 1'b0, 3'd0, 1'b1};
        vt[9]  = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 3'd0, 1'b1};
        vt[10] = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        vt[11] = '{1'b0, 4'hF, 4'h0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 3'd0, 1'b1};
        vt[12] = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 3'd1, 1'b1};
        vt[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd2, 1'b1};

        for (int i = 0; i < 14; i++) begin
            task_valid_i = vt[i].tv; eng_task_ready_i = vt[i].etr; eng_rd_req_i = vt[i].req;
            eng_result_valid_i = vt[i].rv; result_ready_i = vt[i].rr;
            task_i = 64'h1234_0000 + 64'(i);
            #1;
            check($sformatf("v%0d task_ready_o", i), task_ready_o, vt[i].trdy);
            check($sformatf("v%0d eng_task_valid_o", i), eng_task_valid_o, vt[i].etv);
            check($sformatf("v%0d eng_rd_gnt_o", i), eng_rd_gnt_o, vt[i].gnt);
            check($sformatf("v%0d eng_rd_data_val_o", i), eng_rd_data_val_o, vt[i].dval);
            check($sformatf("v%0d result_valid_o", i), result_valid_o, vt[i].resv);
            check($sformatf("v%0d result_tag_o", i), result_tag_o, vt[i].rtag);
            check($sformatf("v%0d busy_o", i), busy_o, vt[i].bsy);
            if (vt[i].etv != 4'h0)
                check($sformatf("v%0d eng_task_o", i), eng_task_o, 64'h1234_0000 + 64'(i));
            if (vt[i].gnt != 4'h0)
                check($sformatf("v%0d ram_rd_addr_o", i), ram_rd_addr_o, 64'h100 + 64'(oh2idx(vt[i].gnt)));
            if (vt[i].resv)
                check($sformatf("v%0d result_o", i), result_o, 64'hA0 + 64'(vt[i].rtag));
            next_cycle();
        end

        // Reset one cycle after a grant: the in-flight read-valid must vanish.
        idle_inputs();
        eng_rd_req_i = 4'h1;
        #1 check("pre-rst gnt", eng_rd_gnt_o, 4'h2 >> 1);
        next_cycle();
        rst_n_i = 1'b0;
        task_valid_i = 1'b1; task_i = 64'hDEAD; eng_task_ready_i = 4'hF; eng_rd_req_i = 4'hF;
        eng_result_valid_i = 4'hF; result_ready_i = 1'b1;
        #1;
        check("in-rst outputs", {task_ready_o, eng_task_valid_o, eng_rd_gnt_o, ram_rd_en_o,
              eng_rd_data_val_o, eng_result_ready_o, result_valid_o, busy_o}, 0);
        check("in-rst eng_task_o", eng_task_o, 0);
        check("in-rst result_o", result_o, 0);
        next_cycle();
        rst_n_i = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("post-rst dval c%0d", c), eng_rd_data_val_o, 0);
            check($sformatf("post-rst busy c%0d", c), busy_o, 0);
            next_cycle();
        end

        // Same-cycle result accept on engine 2 and dispatch; only engines 2/3 ready.
        task_valid_i = 1'b1; eng_task_ready_i = 4'h4;
        #1 check("sc dispatch e2", eng_task_valid_o, 4'h4);
        next_cycle();
        eng_task_ready_i = 4'hC; eng_result_valid_i = 4'h4; result_ready_i = 1'b1;
        #1;
        check("sc dispatch e3", eng_task_valid_o, 4'h8);
        check("sc result_valid", result_valid_o, 1);
        check("sc first tag after rst", result_tag_o, 0);
        check("sc result pop", eng_result_ready_o, 4'h4);
        next_cycle();
        eng_result_valid_i = 4'h0;
        #1;
        check("sc e2 eligible", eng_task_valid_o, 4'h4);
        check("sc pop e3 waits", eng_result_ready_o, 4'h8);
        next_cycle();
        task_valid_i = 1'b0; eng_result_valid_i = 4'h8;
        #1;
        check("sc e3 valid", result_valid_o, 1);
        check("sc e3 tag", result_tag_o, 1);
        next_cycle();

        // Stream 20 tasks with random downstream ready through a small engine model.
        do_reset();
        begin
            int sent = 0;
            int recv = 0;
            int cyc = 0;
            e_has = '0;
            for (int i = 0; i < 4; i++) begin e_pay[i] = '0; e_cnt[i] = 0; end
            while (recv < 20 && cyc < 3000) begin
                task_valid_i = (sent < 20);
                task_i = 64'hC0DE_0000 + 64'(sent);
                result_ready_i = 1'($urandom_range(0, 1));
                for (int i = 0; i < 4; i++) begin
                    eng_task_ready_i[i]   = !e_has[i];
                    eng_result_valid_i[i] = e_has[i] && e_cnt[i] == 0;
                    res_val[i] = e_pay[i];
                end
                #1;
                if (result_valid_o && result_ready_i) begin
                    check($sformatf("stream tag %0d", recv), result_tag_o, 64'(recv % 8));
                    check($sformatf("stream data %0d", recv), result_o, 64'hC0DE_0000 + 64'(recv));
                    e_has[oh2idx(eng_result_ready_o)] = 1'b0;
                    recv++;
                end
                if (task_valid_i && task_ready_o) begin
                    e_pay[oh2idx(eng_task_valid_o)] = task_i;
                    e_has[oh2idx(eng_task_valid_o)] = 1'b1;
                    e_cnt[oh2idx(eng_task_valid_o)] = $urandom_range(0, 3);
                    sent++;
                end
                next_cycle();
                for (int i = 0; i < 4; i++) if (e_cnt[i] > 0) e_cnt[i]--;
                cyc++;
            end
            check("stream results received", recv, 20);
            idle_inputs();
            #1 check("stream drained busy", busy_o, 0);
        end
`else
        // Out-of-order: engine 3 finishes first and returns with its own dispatch tag.
        for (int i = 0; i < 4; i++) begin
            task_valid_i = 1'b1; eng_task_ready_i = 4'hF;
            #1 check($sformatf("ooo dispatch %0d", i), eng_task_valid_o, 4'h1 << i);
            next_cycle();
        end
        task_valid_i = 1'b0; eng_result_valid_i = 4'h8; result_ready_i = 1'b1;
        #1;
        check("ooo result_valid", result_valid_o, 1);
        check("ooo result_o", result_o, 64'hA3);
        check("ooo result_tag", result_tag_o, 3);
        check("ooo pop", eng_result_ready_o, 4'h8);
        next_cycle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
